pipeline_stall_controller: RTL

//  Sequences stall, bubble and flush control for the 5-stage MIPS pipeline.
//  - Merges three sources: load-use hazard (ID vs EX), data-memory wait in MEM, and branch redirect in EX.
//  - Drives PC/IFID/IDEX/EXMEM hold and flush enables from one registered FSM with fixed priority.
//  - Sits between the hazard/forwarding logic and the pipeline registers.

---
 rtl/hazard_pkg.sv | 11 +
 rtl/hazard_perf_counter.sv | 19 +
 rtl/pipeline_stall_controller.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and default widths for the pipeline hazard/stall controller.
package hazard_pkg;
  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FLUSH   = 2'd2
  } state_e;
endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with synchronous active-low reset and clear.
module hazard_perf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst || i_clr)              r_cnt <= '0;
    else if (i_inc && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_count = r_cnt;
endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/bubble/flush sequencer for the 5-stage pipeline (mem wait > branch > load-use).
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int FLUSH_CYC   = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReadIDEX,
  input  logic [REG_W-1:0] RtIDEX,
  input  logic [REG_W-1:0] RsIFID,
  input  logic [REG_W-1:0] RtIFID,
  input  logic             BranchTakenEX,
  input  logic             MemAccessMEM,
  input  logic             DMemReady,
  output logic             PcLoad,
  output logic             IFIDLoad,
  output logic             HazardSel,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             PipeFreeze,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] LoadUseStalls,
  output logic [CNT_W-1:0] MemWaitCycles
);
  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] W_LAST  = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [1:0]        FL_INIT = 2'((FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0);

  state_e            r_state, w_state_nxt;
  logic [WCNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [1:0]        r_flush_cnt, w_flush_cnt_nxt;
  logic              w_mem_stall, w_load_use;

  assign w_mem_stall = MemAccessMEM && !DMemReady;
  assign w_load_use  = MemReadIDEX && (RtIDEX != '0) &&
                       ((RtIDEX == RsIFID) || (RtIDEX == RtIFID));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_flush_cnt_nxt = r_flush_cnt;
    PcLoad     = 1'b1;
    IFIDLoad   = 1'b1;
    HazardSel  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    PipeFreeze = 1'b0;
    MemTimeout = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          PcLoad         = 1'b0;
          IFIDLoad       = 1'b0;
          PipeFreeze     = 1'b1;
          w_state_nxt    = MEMWAIT;
          // counts frozen cycles so far, so the entry cycle is number one
          w_wait_cnt_nxt = WCNT_W'(1);
        end else if (BranchTakenEX) begin
          IFIDFlush = 1'b1;
          IDEXFlush = 1'b1;
          if (FLUSH_CYC > 1) begin
            w_state_nxt     = FLUSH;
            w_flush_cnt_nxt = FL_INIT;
          end
        end else if (w_load_use) begin
          PcLoad    = 1'b0;
          IFIDLoad  = 1'b0;
          HazardSel = 1'b0;
        end
      end
      MEMWAIT: begin
        PcLoad     = 1'b0;
        IFIDLoad   = 1'b0;
        PipeFreeze = 1'b1;
        if (DMemReady) begin
          w_state_nxt = RUN;
        end else if (r_wait_cnt == W_LAST) begin
          MemTimeout  = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      FLUSH: begin
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
        if (r_flush_cnt == '0) w_state_nxt = RUN;
        else                   w_flush_cnt_nxt = r_flush_cnt - 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
    if (!rst) begin
      PcLoad     = 1'b0;
      IFIDLoad   = 1'b0;
      HazardSel  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXFlush  = 1'b1;
      PipeFreeze = 1'b0;
      MemTimeout = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // HazardSel only drops for a load-use bubble once out of reset
  logic w_lu_bubble;
  assign w_lu_bubble = rst && !HazardSel;

  hazard_perf_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk(clk), .rst(rst), .i_inc(w_lu_bubble), .i_clr(1'b0), .o_count(LoadUseStalls)
  );
  hazard_perf_counter #(.CNT_W(CNT_W)) u_mw_cnt (
    .clk(clk), .rst(rst), .i_inc(PipeFreeze), .i_clr(1'b0), .o_count(MemWaitCycles)
  );
`else
  assign LoadUseStalls = '0;
  assign MemWaitCycles = '0;
`endif
endmodule
